fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the instruction decoder.
- Owns the PC, issues requests to instruction memory, and holds fetched words in an IF/ID register that drives the decoder's 32-bit instruction input.
- Accepts redirects using the decoder's 2-bit pc_mux_select encoding (00 jr/jalr, 01 branch, 10 j/jal, 11 sequential).
- Halts permanently on a decoder illegal-instruction flag.

---
 rtl/fetch_stage_pkg.sv | 38 +++
 rtl/fetch_stage_next_pc_calc.sv | 57 +++++
 rtl/fetch_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_fetch_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_pkg
//  Description : Shared definitions for the instruction-fetch stage and the
//                branch unit: pc_mux_select encodings, fetch FSM state
//                encodings, IF/ID entry layout and the default reset PC.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

    // Default PC after reset (word aligned)
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Decoder pc_mux_select encoding
    localparam logic [1:0] PCSEL_JR  = 2'b00;
    localparam logic [1:0] PCSEL_BR  = 2'b01;
    localparam logic [1:0] PCSEL_J   = 2'b10;
    localparam logic [1:0] PCSEL_SEQ = 2'b11;

    // Fetch FSM state encodings
    localparam logic [1:0] S_REQ      = 2'd0;
    localparam logic [1:0] S_WAIT_OUT = 2'd1;
    localparam logic [1:0] S_DROP     = 2'd2;
    localparam logic [1:0] S_HALT     = 2'd3;

    // One fetched word together with the address it came from
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } if_id_t;

    // Force an address onto a word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_next_pc_calc.sv
`default_nettype none
// ============================================================================
//  Module      : next_pc_calc
//  Description : Combinational redirect target generation. Decodes the
//                decoder's pc_mux_select value and reports whether the
//                redirect actually changes control flow.
//  Ports       : redir_valid/sel/taken/pc/imm/iindex/reg - redirect request
//                redirect - effective redirect this cycle
//                target   - new word-aligned PC
//  Revision    : 1.0 - initial release
// ============================================================================
module next_pc_calc
    import fetch_stage_pkg::*;
(
    input  logic        redir_valid,
    input  logic [1:0]  redir_sel,
    input  logic        redir_taken,
    input  logic [31:0] redir_pc,
    input  logic [15:0] redir_imm,
    input  logic [25:0] redir_iindex,
    input  logic [31:0] redir_reg,
    output logic        redirect,
    output logic [31:0] target
);

    logic [31:0] pc4;
    logic [31:0] br_offset;

    assign pc4       = redir_pc + 32'd4;
    assign br_offset = {{14{redir_imm[15]}}, redir_imm, 2'b00};

    always_comb begin
        redirect = 1'b0;
        target   = pc4;
        case (redir_sel)
            PCSEL_JR: begin
                redirect = redir_valid;
                target   = word_align(redir_reg);
            end
            PCSEL_BR: begin
                // A not-taken branch simply continues sequential fetch
                redirect = redir_valid & redir_taken;
                target   = pc4 + br_offset;
            end
            PCSEL_J: begin
                redirect = redir_valid;
                target   = {pc4[31:28], redir_iindex, 2'b00};
            end
            default: begin
                redirect = 1'b0;
                target   = pc4;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction-fetch stage. Owns the PC, runs the instruction
//                memory request/ready handshake, and holds the fetched word in
//                an IF/ID register (plus a one-entry skid buffer) for the
//                decoder. Accepts redirects and halts on an illegal opcode.
//  Ports       : clk, rst_n (async, active-low)
//                imem_req/addr/ready/rdata - instruction memory handshake
//                id_valid/instr/pc, id_stall - IF/ID interface to decoder
//                redir_*  - redirect request from decoder / branch unit
//                illegal  - decoder illegal flag, halted - fetch stopped
//                stat_fetched/stat_squashed - only with FETCH_STATS_EN
//  Options     : `define FETCH_STATS_EN adds the fetched/squashed counters
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic              id_valid,
    output logic [31:0]       id_instr,
    output logic [ADDR_W-1:0] id_pc,
    input  logic              id_stall,
    input  logic              redir_valid,
    input  logic [1:0]        redir_sel,
    input  logic              redir_taken,
    input  logic [31:0]       redir_pc,
    input  logic [15:0]       redir_imm,
    input  logic [25:0]       redir_iindex,
    input  logic [31:0]       redir_reg,
    input  logic              illegal,
`ifdef FETCH_STATS_EN
    output logic [31:0]       stat_fetched,
    output logic [31:0]       stat_squashed,
`endif
    output logic              halted
);

    localparam logic [ADDR_W-1:0] PC_INIT = {RESET_PC[ADDR_W-1:2], 2'b00};

    logic [1:0]        state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [ADDR_W-1:0] drop_target, drop_target_n;
    logic              started;
    logic              halt_pend, halt_pend_n;
    logic              id_valid_n;
    logic [31:0]       id_instr_n;
    logic [ADDR_W-1:0] id_pc_n;
    if_id_t            skid, skid_n;
    logic              fetched_inc, squashed_inc;

    logic              redirect;
    logic [31:0]       target;
    logic              halt_req;
    logic              handshake;
    logic              outstanding;

    next_pc_calc u_next_pc_calc (
        .redir_valid  (redir_valid),
        .redir_sel    (redir_sel),
        .redir_taken  (redir_taken),
        .redir_pc     (redir_pc),
        .redir_imm    (redir_imm),
        .redir_iindex (redir_iindex),
        .redir_reg    (redir_reg),
        .redirect     (redirect),
        .target       (target)
    );

    // 'started' keeps the request low until the first edge after reset release
    assign imem_req    = started & ((state == S_REQ) | (state == S_DROP));
    assign imem_addr   = pc;
    assign handshake   = imem_req & imem_ready;
    assign outstanding = imem_req & ~imem_ready;
    assign halt_req    = id_valid & illegal;
    // A pending halt waits out an outstanding request but already reports halted
    assign halted      = (state == S_HALT) | halt_pend;

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        drop_target_n = drop_target;
        halt_pend_n   = halt_pend;
        id_valid_n    = id_valid;
        id_instr_n    = id_instr;
        id_pc_n       = id_pc;
        skid_n        = skid;
        fetched_inc   = 1'b0;
        squashed_inc  = 1'b0;
        case (state)
            S_REQ: begin
                if (halt_req) begin
                    // id_* are left alone so the offending instruction stays visible
                    if (outstanding) begin
                        halt_pend_n = 1'b1;
                        state_n     = S_DROP;
                    end else begin
                        squashed_inc = handshake;
                        state_n      = S_HALT;
                    end
                end else if (redirect) begin
                    id_valid_n = 1'b0;
                    if (outstanding) begin
                        drop_target_n = target;
                        state_n       = S_DROP;
                    end else begin
                        pc_n         = target;
                        squashed_inc = handshake;
                    end
                end else if (handshake) begin
                    pc_n = pc + ADDR_W'(4);
                    if (!id_valid || !id_stall) begin
                        id_valid_n  = 1'b1;
                        id_instr_n  = imem_rdata;
                        id_pc_n     = pc;
                        fetched_inc = 1'b1;
                    end else begin
                        skid_n  = '{instr: imem_rdata, pc: pc};
                        state_n = S_WAIT_OUT;
                    end
                end else if (id_valid && !id_stall) begin
                    id_valid_n = 1'b0;
                end
            end
            S_WAIT_OUT: begin
                if (halt_req) begin
                    state_n = S_HALT;
                end else if (redirect) begin
                    id_valid_n   = 1'b0;
                    pc_n         = target;
                    squashed_inc = 1'b1;
                    state_n      = S_REQ;
                end else if (!id_stall) begin
                    id_valid_n  = 1'b1;
                    id_instr_n  = skid.instr;
                    id_pc_n     = skid.pc;
                    fetched_inc = 1'b1;
                    state_n     = S_REQ;
                end
            end
            S_DROP: begin
                if (halt_pend) begin
                    if (imem_ready) begin
                        squashed_inc = 1'b1;
                        state_n      = S_HALT;
                    end
                end else begin
                    if (redirect) begin
                        id_valid_n = 1'b0;
                    end
                    if (imem_ready) begin
                        // A redirect arriving now supersedes the stored one
                        pc_n         = redirect ? target : drop_target;
                        squashed_inc = 1'b1;
                        state_n      = S_REQ;
                    end else if (redirect) begin
                        drop_target_n = target;
                    end
                end
            end
            default: begin
                state_n = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_REQ;
            pc          <= PC_INIT;
            drop_target <= PC_INIT;
            started     <= 1'b0;
            halt_pend   <= 1'b0;
            id_valid    <= 1'b0;
            id_instr    <= 32'd0;
            id_pc       <= '0;
            skid        <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            drop_target <= drop_target_n;
            started     <= 1'b1;
            halt_pend   <= halt_pend_n;
            id_valid    <= id_valid_n;
            id_instr    <= id_instr_n;
            id_pc       <= id_pc_n;
            skid        <= skid_n;
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fetched  <= 32'd0;
            stat_squashed <= 32'd0;
        end else begin
            if (fetched_inc) begin
                stat_fetched <= stat_fetched + 32'd1;
            end
            if (squashed_inc) begin
                stat_squashed <= stat_squashed + 32'd1;
            end
        end
    end
`else
    logic unused_stat_events;
    assign unused_stat_events = fetched_inc ^ squashed_inc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage. A per-cycle vector table
//                drives redirect/stall/ready inputs and states the expected
//                fetch address and IF/ID contents; reset, delayed-ready and
//                illegal-halt sequences are written out by hand.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_stall = 1'b0;
    logic        redir_valid = 1'b0;
    logic [1:0]  redir_sel = 2'b11;
    logic        redir_taken = 1'b0;
    logic [31:0] redir_pc = 32'd0;
    logic [15:0] redir_imm = 16'd0;
    logic [25:0] redir_iindex = 26'd0;
    logic [31:0] redir_reg = 32'd0;
    logic        illegal = 1'b0;
    logic        halted;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_squashed;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Memory contents: each word encodes its own address
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    assign imem_rdata = instr_of(imem_addr);

    fetch_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .id_valid     (id_valid),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .id_stall     (id_stall),
        .redir_valid  (redir_valid),
        .redir_sel    (redir_sel),
        .redir_taken  (redir_taken),
        .redir_pc     (redir_pc),
        .redir_imm    (redir_imm),
        .redir_iindex (redir_iindex),
        .redir_reg    (redir_reg),
        .illegal      (illegal),
`ifdef FETCH_STATS_EN
        .stat_fetched (stat_fetched),
        .stat_squashed(stat_squashed),
`endif
        .halted       (halted)
    );

    typedef struct {
        logic        ready;
        logic        stall;
        logic        rv;
        logic [1:0]  sel;
        logic        taken;
        logic [31:0] rpc;
        logic [15:0] imm;
        logic [25:0] idx;
        logic [31:0] rreg;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_idv;
        logic [31:0] e_idpc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic s, input logic rv,
                                input logic [1:0] sel, input logic tk,
                                input logic [31:0] rpc, input logic [15:0] imm,
                                input logic [25:0] idx, input logic [31:0] rreg,
                                input logic ereq, input logic [31:0] eaddr,
                                input logic eidv, input logic [31:0] eidpc);
        vec_t v;
        v.ready = r;    v.stall = s;   v.rv = rv;     v.sel = sel;
        v.taken = tk;   v.rpc = rpc;   v.imm = imm;   v.idx = idx;
        v.rreg = rreg;  v.e_req = ereq; v.e_addr = eaddr;
        v.e_idv = eidv; v.e_idpc = eidpc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " imem_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, " id_valid"}, {31'd0, id_valid}, 32'd0);
        chk({tag, " id_instr"}, id_instr, 32'd0);
        chk({tag, " id_pc"},    id_pc,    32'd0);
        chk({tag, " halted"},   {31'd0, halted}, 32'd0);
    endtask

    task automatic no_redirect();
        redir_valid = 1'b0; redir_sel = 2'b11; redir_taken = 1'b0;
    endtask

    initial begin
        // Sequential run, stall/skid, branch, drop, jr, back-to-back redirects, wrap
        vecs.push_back(mk(1,0,0,2'b11,0,0,0,0,0,               1,32'h0,1'b0,32'h0));
        vecs.push_back(mk(1,0,0,2'b11,0,0,0,0,0,               1,32'h4,1'b1,32'h0));
        vecs.push_back(mk(1,1,0,2'b11,0,0,0,0,0,               1,32'h8,1'b1,32'h4));
        vecs.push_back(mk(1,1,0,2'b11,0,0,0,0,0,               0,32'hC,1'b1,32'h4));
        vecs.push_back(mk(1,0,0,2'b11,0,0,0,0,0,               0,32'hC,1'b1,32'h4));
        vecs.push_back(mk(1,0,0,2'b11,0,0,0,0,0,               1,32'hC,1'b1,32'h8));
        vecs.push_back(mk(1,0,0,2'b11,0,0,0,0,0,               1,32'h10,1'b1,32'hC));
        vecs.push_back(mk(1,0,1,2'b01,1,32'h100,16'hFFFE,0,0,  1,32'h14,1'b1,32'h10));
        vecs.push_back(mk(1,0,0,2'b11,0,0,0,0,0,               1,32'hFC,1'b0,32'h0));
        vecs.push_back(mk(1,0,1,2'b01,0,32'h100,16'h0010,0,0,  1,32'h100,1'b1,32'hFC));
        vecs.push_back(mk(1,0,1,2'b11,0,32'h100,0,0,0,         1,32'h104,1'b1,32'h100));
        vecs.push_back(mk(0,0,1,2'b10,0,32'h108,0,26'h40,0,    1,32'h108,1'b1,32'h104));
        vecs.push_back(mk(0,0,0,2'b11,0,0,0,0,0,               1,32'h108,1'b0,32'h0));
        vecs.push_back(mk(1,0,0,2'b11,0,0,0,0,0,               1,32'h108,1'b0,32'h0));
        vecs.push_back(mk(1,0,0,2'b11,0,0,0,0,0,               1,32'h100,1'b0,32'h0));
        vecs.push_back(mk(0,0,0,2'b11,0,0,0,0,0,               1,32'h104,1'b1,32'h100));
        vecs.push_back(mk(0,0,0,2'b11,0,0,0,0,0,               1,32'h104,1'b0,32'h0));
        vecs.push_back(mk(1,0,0,2'b11,0,0,0,0,0,               1,32'h104,1'b0,32'h0));
        vecs.push_back(mk(1,0,1,2'b00,0,0,0,0,32'h2003,        1,32'h108,1'b1,32'h104));
        vecs.push_back(mk(0,0,1,2'b10,0,32'h1000_0010,0,26'h100,0, 1,32'h2000,1'b0,32'h0));
        vecs.push_back(mk(1,0,1,2'b00,0,0,0,0,32'h3000_0008,   1,32'h2000,1'b0,32'h0));
        vecs.push_back(mk(1,0,0,2'b11,0,0,0,0,0,               1,32'h3000_0008,1'b0,32'h0));
        vecs.push_back(mk(1,1,0,2'b11,0,0,0,0,0,               1,32'h3000_000C,1'b1,32'h3000_0008));
        vecs.push_back(mk(1,1,1,2'b01,1,32'hFFFF_FFF8,16'h0001,0,0, 0,32'h0,1'b1,32'h3000_0008));
        vecs.push_back(mk(1,0,0,2'b11,0,0,0,0,0,               1,32'h0,1'b0,32'h0));
        vecs.push_back(mk(0,1,0,2'b11,0,0,0,0,0,               1,32'h4,1'b1,32'h0));

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        imem_ready = 1'b1;
        #1;
        chk("req before first edge", {31'd0, imem_req}, 32'd0);

        foreach (vecs[i]) begin
            @(negedge clk);
            chk($sformatf("v%0d imem_req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
            if (vecs[i].e_req)
                chk($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d id_valid", i), {31'd0, id_valid}, {31'd0, vecs[i].e_idv});
            if (vecs[i].e_idv) begin
                chk($sformatf("v%0d id_pc", i), id_pc, vecs[i].e_idpc);
                chk($sformatf("v%0d id_instr", i), id_instr, instr_of(vecs[i].e_idpc));
            end
            chk($sformatf("v%0d halted", i), {31'd0, halted}, 32'd0);
            imem_ready   = vecs[i].ready;
            id_stall     = vecs[i].stall;
            redir_valid  = vecs[i].rv;
            redir_sel    = vecs[i].sel;
            redir_taken  = vecs[i].taken;
            redir_pc     = vecs[i].rpc;
            redir_imm    = vecs[i].imm;
            redir_iindex = vecs[i].idx;
            redir_reg    = vecs[i].rreg;
        end

        // Illegal while a request to 0x4 is outstanding: halt reported at once,
        // the request completes before imem_req drops
        @(negedge clk);
        chk("pre-ill addr", imem_addr, 32'h4);
        chk("pre-ill id_pc", id_pc, 32'h0);
        no_redirect();
        illegal = 1'b1;
        @(negedge clk);
        chk("ill-pend halted", {31'd0, halted}, 32'd1);
        chk("ill-pend req", {31'd0, imem_req}, 32'd1);
        chk("ill-pend addr", imem_addr, 32'h4);
        chk("ill-pend id_valid", {31'd0, id_valid}, 32'd1);
        illegal = 1'b0;
        imem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("halt%0d req", k), {31'd0, imem_req}, 32'd0);
            chk($sformatf("halt%0d halted", k), {31'd0, halted}, 32'd1);
            chk($sformatf("halt%0d id_valid", k), {31'd0, id_valid}, 32'd1);
            chk($sformatf("halt%0d id_pc", k), id_pc, 32'h0);
            chk($sformatf("halt%0d id_instr", k), id_instr, instr_of(32'h0));
            redir_valid = 1'b1; redir_sel = 2'b00; redir_reg = 32'h40;
            id_stall = 1'b0;
        end

        // Asynchronous reset from the halted state
        rst_n = 1'b0;
        #1;
        chk_reset("re-reset");
        no_redirect();
        imem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Ready delayed three cycles: address 0 held for four cycles
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("dly%0d req", k), {31'd0, imem_req}, 32'd1);
            chk($sformatf("dly%0d addr", k), imem_addr, 32'h0);
            chk($sformatf("dly%0d id_valid", k), {31'd0, id_valid}, 32'd0);
            imem_ready = (k == 3);
        end
        @(negedge clk);
        chk("dly data id_valid", {31'd0, id_valid}, 32'd1);
        chk("dly data id_instr", id_instr, instr_of(32'h0));
        chk("dly data addr", imem_addr, 32'h4);

        // Illegal with ready high: halted and request dropped on the next edge
        illegal = 1'b1;
        @(negedge clk);
        illegal = 1'b0;
        chk("ill halted", {31'd0, halted}, 32'd1);
        chk("ill req", {31'd0, imem_req}, 32'd0);
        chk("ill id_valid", {31'd0, id_valid}, 32'd1);
        chk("ill id_pc", id_pc, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
